shift_ser_tx: RTL and testbench
===============================

Name: shift_ser_tx

Overview:
- Downstream stage of the team's 16-bit parallel-load shift register.
- Accepts a parallel word over a valid/ready handshake and serialises it one bit per consumed beat, MSB-first or LSB-first.
- Uses the same direction encoding as the shift register it sits behind.
- Frames are bounded by a bit counter; a one-cycle done pulse marks frame end for the upstream controller.

Parameters:
- WIDTH, 16, word width in bits (legal range 2..64).
- CNT_W, 7, bit-counter width; must be at least clog2(WIDTH+2).

Ports:
- i_clk     input   1      clock, rising edge
- i_rst     input   1      reset, asynchronous, active-high
- i_valid   input   1      upstream word valid
- o_ready   output  1      block can accept a word
- i_data    input   WIDTH  parallel word
- i_dir     input   1      0 = MSB first (left shift), 1 = LSB first (right shift); sampled with the word
- o_sdata   output  1      serial data bit
- o_sval    output  1      serial bit valid
- i_sready  input   1      downstream accepts the current bit
- o_busy    output  1      frame in progress
- o_done    output  1      one-cycle pulse after the final bit is consumed

Behaviour:
- Reset: i_rst asynchronous, active-high; clock i_clk. While reset is asserted:
  - state = IDLE; internal shift register = 0; counter = 0; stored direction = 0.
  - o_sdata = 0, o_sval = 0, o_busy = 0, o_done = 0, o_ready = 0.
  - o_ready rises in the first cycle after reset deasserts.
- States: IDLE, SHIFT, DONE; a PAR state is added when the optional feature is compiled in.
- IDLE:
  - o_ready = 1.
  - On a rising edge with i_valid && o_ready: i_data goes into the shift register, i_dir into the direction register, counter = WIDTH, next state = SHIFT.
- SHIFT:
  - o_sval = 1; o_ready = 0; o_busy = 1.
  - o_sdata = shreg[WIDTH-1] when dir = 0, shreg[0] when dir = 1. It is a direct decode of registered state, with no combinational path from any input.
  - A bit is consumed on an edge where o_sval && i_sready. On consume, the shift register shifts toward the exposed end with zero fill, and the counter decrements.
  - Consume with counter == 1: next state = DONE (or PAR when the feature is enabled).
  - i_sready low: shift register, counter and o_sdata hold; o_sval stays 1. No limit on stall length.
- DONE:
  - Lasts exactly one cycle: o_done = 1, o_busy = 1, o_sval = 0, o_ready = 0; then IDLE.
- Latency and throughput:
  - First bit is valid in the cycle after acceptance.
  - With i_sready held at 1, a frame occupies WIDTH+1 cycles after acceptance.
  - Minimum word-to-word spacing is WIDTH+2 cycles.
- Handshake boundaries:
  - i_valid while busy is ignored; i_data is not sampled.
  - i_valid and i_data may change freely while o_ready = 0.
  - i_dir is captured only at acceptance; changes mid-frame have no effect.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is discarded; no o_done is produced.

Optional Feature:
- Macro: SHIFT_SER_TX_PARITY_EN.
- Defined:
  - At acceptance, even parity (XOR of all WIDTH data bits) is latched.
  - After the last data bit is consumed, state PAR presents the parity bit with o_sval = 1, subject to the same i_sready stall rule.
  - Consuming it moves the FSM to DONE.
  - Frame length is WIDTH+1 bits; minimum spacing is WIDTH+3 cycles.
- Undefined: no PAR state and no parity register; frame is exactly WIDTH bits.

Decomposition:
- Shared package shift_pkg contains:
  - the state enum typedef ser_state_t (IDLE, SHIFT, PAR, DONE);
  - direction constants DIR_MSB_FIRST = 1'b0 and DIR_LSB_FIRST = 1'b1, shared with the shift register;
  - default width constant SHIFT_W = 16.
- No sub-module: the counter and shifter are small and tightly coupled to the FSM, so a single module is required.

Test Plan:
- Reset: assert i_rst mid-cycle with no clock edge -> all outputs 0 immediately. Deassert -> o_ready = 1 on the next cycle, o_sval = 0.
- MSB-first: i_data = 16'hA5C3, i_dir = 0, i_sready = 1 -> o_sdata over 16 consecutive cycles = 1010 0101 1100 0011, then o_done = 1 for one cycle, then o_ready = 1.
- LSB-first: i_data = 16'hA5C3, i_dir = 1 -> bits 1100 0011 1010 0101 (bit0 first), o_done after the 16th bit.
- Stall and ignore:
  - i_sready = 0 for 3 cycles while bit index 5 is presented -> same o_sdata held, o_sval = 1 for 19 cycles total, bit sequence unchanged.
  - i_valid pulsed with 16'hFFFF mid-frame -> ignored, o_ready = 0.
- Reset mid-frame: i_rst pulse after 7 bits of 16'h00FF -> o_sval = 0, no o_done. A new word 16'h8001 afterwards serialises cleanly as 1000 0000 0000 0001.
- Parity (SHIFT_SER_TX_PARITY_EN defined): 16'h0001 -> 17th bit = 1; 16'h0003 -> 17th bit = 0; o_done follows the 17th consumed bit.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift register and its serialiser stage.
package shift_pkg;

  localparam int unsigned SHIFT_W = 16;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/shift_ser_tx.sv
// Parallel-to-serial transmitter: accepts a word over valid/ready and
// emits it one bit per consumed beat, MSB- or LSB-first.
// Optional trailing even-parity bit when SHIFT_SER_TX_PARITY_EN is defined.
module shift_ser_tx
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_W,
  parameter int unsigned CNT_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_dir,
  output logic             o_sdata,
  output logic             o_sval,
  input  logic             i_sready,
  output logic             o_busy,
  output logic             o_done
);

  ser_state_t       state_q, state_nx;
  logic [WIDTH-1:0] shreg_q, shreg_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             dir_q, dir_nx;
`ifdef SHIFT_SER_TX_PARITY_EN
  logic             par_q, par_nx;
`endif

  logic ready_nx, sval_nx, busy_nx, done_nx, sdata_nx;

  // State and output registers; outputs are precomputed from next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_MSB_FIRST;
`ifdef SHIFT_SER_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
      o_ready <= 1'b0;
      o_sval  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sdata <= 1'b0;
    end else begin
      state_q <= state_nx;
      shreg_q <= shreg_nx;
      cnt_q   <= cnt_nx;
      dir_q   <= dir_nx;
`ifdef SHIFT_SER_TX_PARITY_EN
      par_q   <= par_nx;
`endif
      o_ready <= ready_nx;
      o_sval  <= sval_nx;
      o_busy  <= busy_nx;
      o_done  <= done_nx;
      o_sdata <= sdata_nx;
    end
  end

  // Next-state, datapath update and next output values.
  always_comb begin
    state_nx = state_q;
    shreg_nx = shreg_q;
    cnt_nx   = cnt_q;
    dir_nx   = dir_q;
`ifdef SHIFT_SER_TX_PARITY_EN
    par_nx   = par_q;
`endif
    ready_nx = 1'b0;
    sval_nx  = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    sdata_nx = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid && o_ready) begin
          shreg_nx = i_data;
          dir_nx   = i_dir;
          cnt_nx   = CNT_W'(WIDTH);
`ifdef SHIFT_SER_TX_PARITY_EN
          par_nx   = ^i_data;
`endif
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (o_sval && i_sready) begin
          shreg_nx = (dir_q == DIR_MSB_FIRST) ? (shreg_q << 1) : (shreg_q >> 1);
          cnt_nx   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
`ifdef SHIFT_SER_TX_PARITY_EN
            state_nx = PAR;
`else
            state_nx = DONE;
`endif
          end
        end
      end
`ifdef SHIFT_SER_TX_PARITY_EN
      PAR: begin
        if (o_sval && i_sready) state_nx = DONE;
      end
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    ready_nx = (state_nx == IDLE);
    busy_nx  = (state_nx != IDLE);
    done_nx  = (state_nx == DONE);
    if (state_nx == SHIFT) begin
      sval_nx  = 1'b1;
      sdata_nx = (dir_nx == DIR_MSB_FIRST) ? shreg_nx[WIDTH-1] : shreg_nx[0];
    end
`ifdef SHIFT_SER_TX_PARITY_EN
    if (state_nx == PAR) begin
      sval_nx  = 1'b1;
      sdata_nx = par_nx;
    end
`endif
  end

endmodule

// File: tb/tb_shift_ser_tx.sv
// Self-checking bench for shift_ser_tx; scoreboard of expected serial bits.
// Build with SHIFT_SER_TX_PARITY_EN to also cover the parity bit.
module tb_shift_ser_tx;

  localparam int unsigned W = 16;
`ifdef SHIFT_SER_TX_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk, rst, valid, ready, dir, sdata, sval, sready, busy, done;
  logic [W-1:0] data;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   consumed = 0;
  logic exp_q[$];

  shift_ser_tx #(.WIDTH(W), .CNT_W(7)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .o_ready (ready),
    .i_data  (data),
    .i_dir   (dir),
    .o_sdata (sdata),
    .o_sval  (sval),
    .i_sready(sready),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for ready, present one word, and push its expected bit stream.
  task automatic send_word(input logic [W-1:0] d, input logic dr);
    int cyc = 0;
    @(negedge clk);
    while (!ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!ready) begin
      n_fail++;
      $display("FAIL send_ready_timeout: ready=%0b, required 1", ready);
    end
    valid = 1'b1;
    data  = d;
    dir   = dr;
    for (int i = 0; i < int'(W); i++) exp_q.push_back(dr ? d[i] : d[W-1-i]);
`ifdef SHIFT_SER_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    @(posedge clk);
    #1 valid = 1'b0;
    data = '0;
  endtask

  // Follow a frame to its done pulse, checking each consumed bit and the frame shape.
  task automatic wait_frame(input int exp_sval, input string name);
    int   cyc = 0;
    int   sval_n = 0;
    bit   got_done = 1'b0;
    logic eb;
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got_done = 1'b1;
      end else if (sval) begin
        sval_n++;
        n_checks++;
        if (!busy) begin
          n_fail++;
          $display("FAIL %s_busy: busy=%0b, required 1", name, busy);
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s_extra_bit: sdata=%0b, required no bit", name, sdata);
        end else if (sready) begin
          eb = exp_q.pop_front();
          consumed++;
          n_checks++;
          if (sdata !== eb) begin
            n_fail++;
            $display("FAIL %s_bit%0d: sdata=%0b, required %0b", name, consumed - 1, sdata, eb);
          end
        end else begin
          n_checks++;
          if (sdata !== exp_q[0]) begin
            n_fail++;
            $display("FAIL %s_stall_hold: sdata=%0b, required %0b", name, sdata, exp_q[0]);
          end
        end
      end
    end
    n_checks++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done=%0b, required 1", name, done);
    end
    n_checks++;
    if (sval_n != exp_sval) begin
      n_fail++;
      $display("FAIL %s_sval_cycles: got %0d, required %0d", name, sval_n, exp_sval);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_bits_left: %0d, required 0", name, exp_q.size());
    end
    n_checks++;
    if ({sval, busy, ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s_done_cycle: sval/busy/ready=%b, required 010", name, {sval, busy, ready});
    end
    @(negedge clk);
    n_checks++;
    if ({done, ready, busy, sval} !== 4'b0100) begin
      n_fail++;
      $display("FAIL %s_after_done: done/ready/busy/sval=%b, required 0100", name, {done, ready, busy, sval});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; data = '0; dir = 1'b0; sready = 1'b1;
    #1;
    n_checks++;
    if ({sdata, sval, busy, done, ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: %b, required 00000", {sdata, sval, busy, done, ready});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || sval !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%0b sval=%0b, required ready=1 sval=0", ready, sval);
    end
    // Asynchronous assertion between edges must clear outputs at once.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({sdata, sval, busy, done, ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_async: %b, required 00000", {sdata, sval, busy, done, ready});
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_msb_first();
    send_word(16'hA5C3, 1'b0);
    wait_frame(FRAME, "msb");
  endtask

  // LSB-first; toggling dir mid-frame must not disturb the stream.
  task automatic test_lsb_first();
    send_word(16'hA5C3, 1'b1);
    fork
      wait_frame(FRAME, "lsb");
      begin
        repeat (4) @(posedge clk);
        #1 dir = 1'b0;
        repeat (4) @(posedge clk);
        #1 dir = 1'b1;
      end
    join
  endtask

  // Three-cycle stall on bit index 5 plus an ignored mid-frame valid.
  task automatic test_stall_ignore();
    consumed = 0;
    send_word(16'hA5C3, 1'b0);
    fork
      wait_frame(FRAME + 3, "stall");
      begin
        int cyc = 0;
        while (consumed < 5 && cyc < 100) begin
          @(negedge clk);
          #1 cyc++;
        end
        @(posedge clk);
        #1 sready = 1'b0;
        valid = 1'b1;
        data  = 16'hFFFF;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_ready: ready=%0b, required 0", ready);
        end
        repeat (3) @(posedge clk);
        #1 sready = 1'b1;
        valid = 1'b0;
        data  = '0;
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    int   k = 0;
    int   cyc = 0;
    logic eb;
    send_word(16'h00FF, 1'b0);
    while (k < 7 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (sval && sready) begin
        eb = exp_q.pop_front();
        n_checks++;
        if (sdata !== eb) begin
          n_fail++;
          $display("FAIL midrst_bit%0d: sdata=%0b, required %0b", k, sdata, eb);
        end
        k++;
      end
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if ({sdata, sval, busy, done, ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: %b, required 00000", {sdata, sval, busy, done, ready});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || sval !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_no_done: done=%0b sval=%0b, required 0 0", done, sval);
      end
    end
    send_word(16'h8001, 1'b0);
    wait_frame(FRAME, "after_rst");
  endtask

  task automatic test_back_to_back();
    send_word(16'h1234, 1'b0);
    wait_frame(FRAME, "b2b_a");
    send_word(16'hFEDC, 1'b1);
    wait_frame(FRAME, "b2b_b");
  endtask

`ifdef SHIFT_SER_TX_PARITY_EN
  task automatic test_parity();
    send_word(16'h0001, 1'b0);
    wait_frame(FRAME, "par_odd");
    send_word(16'h0003, 1'b0);
    wait_frame(FRAME, "par_even");
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall_ignore();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef SHIFT_SER_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
